// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: burst FSM states and default line/store geometry for mem_burst_responder
package mem_resp_pkg;
  localparam int CACHE_B = 4;
  localparam int DEF_LINE_WORDS = 2 ** (CACHE_B - 2);
  localparam int DEF_DEPTH_WORDS = 1024;
  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;
endpackage

// File: rtl/mem_resp_counter.sv
// mem_resp_counter: loadable wrapping up/down counter shared by the latency and beat phases
module mem_resp_counter #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load,
  input  logic [W-1:0] val,
  input  logic         en,
  input  logic         up,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt <= '0;
    else if (load) cnt <= val;
    else if (en) cnt <= up ? cnt + 1'b1 : cnt - 1'b1;
endmodule

// File: rtl/mem_burst_responder.sv
// mem_burst_responder: cache-line burst memory responder; define MEM_RESP_CWF_EN for critical-word-first reads
module mem_burst_responder
  import mem_resp_pkg::*;
#(
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int LATENCY = 2,
  localparam int BW = LINE_WORDS > 1 ? $clog2(LINE_WORDS) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_i,
  input  logic          we_i,
  input  logic [31:0]   addr_i,
  input  logic [31:0]   wdata_i,
  output logic          busy_o,
  output logic          rvalid_o,
  output logic [31:0]   rdata_o,
  output logic          wready_o,
  output logic [BW-1:0] beat_o,
  output logic          done_o
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int LTW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  localparam int CW = LTW > BW ? LTW : BW;
  state_t state, state_d;
  logic we_q, accept, last, cnt_load, cnt_en, cnt_up, unused;
  logic [AW-1:0] line_q, idx;
  logic [BW-1:0] beat, start;
  logic [CW-1:0] cnt, cnt_val;
  logic [31:0] mem [DEPTH_WORDS];
  assign accept = state == IDLE && req_i;
  assign last = cnt == CW'(LINE_WORDS - 1);
  assign unused = ^{addr_i[31:AW+2], addr_i[1:0]};
  always_comb begin
    state_d = state;
    cnt_load = 1'b0;
    cnt_val = '0;
    cnt_en = 1'b0;
    cnt_up = 1'b0;
    unique case (state)
      IDLE: begin
        state_d = req_i ? WAIT : IDLE;
        cnt_load = req_i;
        cnt_val = CW'(LATENCY - 1);
      end
      WAIT: begin
        state_d = cnt == '0 ? BURST : WAIT;
        cnt_load = cnt == '0;
        cnt_en = cnt != '0;
      end
      BURST: begin
        state_d = last ? DONE : BURST;
        cnt_en = 1'b1;
        cnt_up = 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state <= IDLE;
      we_q <= 1'b0;
      line_q <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        we_q <= we_i;
        line_q <= addr_i[AW+1:2] & ~AW'(LINE_WORDS - 1);
      end
    end
  mem_resp_counter #(.W(CW)) u_cnt (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .load(cnt_load),
    .val(cnt_val),
    .en(cnt_en),
    .up(cnt_up),
    .cnt(cnt)
  );
`ifdef MEM_RESP_CWF_EN
  logic [BW-1:0] off_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) off_q <= '0;
    else if (accept) off_q <= addr_i[BW+1:2];
  // write-backs always stream the line in order; only fills start at the requested word
  assign start = we_q ? '0 : off_q;
`else
  assign start = '0;
`endif
  assign beat = start + BW'(cnt);
  assign idx = line_q | AW'(beat);
  assign busy_o = state != IDLE;
  assign done_o = state == DONE;
  assign rvalid_o = state == BURST && !we_q;
  assign wready_o = state == BURST && we_q;
  assign beat_o = state == BURST ? beat : '0;
  assign rdata_o = rvalid_o ? mem[idx] : '0;
  always_ff @(posedge clk_i)
    if (wready_o) mem[idx] <= wdata_i;
endmodule

// File: tb/tb_mem_burst_responder.sv
// tb_mem_burst_responder: vector table, randomized model checks and reset/back-to-back sequences
module tb_mem_burst_responder;
  localparam int LW = 4, LAT = 2, DEPTH = 1024;
  typedef logic [LW-1:0][31:0] line_t;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    line_t       d;
  } vec_t;
  logic clk_i = 1'b0, rst_ni = 1'b0, req_i = 1'b0, we_i = 1'b0;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic busy_o, rvalid_o, wready_o, done_o;
  logic [1:0] beat_o;
  logic [31:0] rdata_o;
  int n_tests = 0, n_fail = 0;
  logic [31:0] ref_mem [DEPTH];
  vec_t tbl [7];
  line_t la, ld, lp;
  mem_burst_responder #(.LINE_WORDS(LW), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .req_i(req_i),
    .we_i(we_i),
    .addr_i(addr_i),
    .wdata_i(wdata_i),
    .busy_o(busy_o),
    .rvalid_o(rvalid_o),
    .rdata_o(rdata_o),
    .wready_o(wready_o),
    .beat_o(beat_o),
    .done_o(done_o)
  );
  always #5 clk_i = ~clk_i;
  function automatic line_t mk(logic [31:0] a, logic [31:0] b, logic [31:0] c, logic [31:0] e);
    line_t r;
    r[0] = a;
    r[1] = b;
    r[2] = c;
    r[3] = e;
    return r;
  endfunction
  function automatic int beat_of(logic we, logic [31:0] addr, int j);
    int s;
    s = 0;
`ifdef MEM_RESP_CWF_EN
    if (!we) s = int'(addr[3:2]);
`endif
    return (s + j) % LW;
  endfunction
  function automatic int idx_of(logic [31:0] addr, int b);
    int w;
    w = int'(addr >> 2);
    return ((w / LW) * LW + b) % DEPTH;
  endfunction
  task automatic check(input string name, input logic [37:0] exp);
    logic [37:0] act;
    act = {busy_o, rvalid_o, wready_o, done_o, beat_o, rdata_o};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic burst(input string name, input logic we, input logic [31:0] addr, input line_t d, input bit hold);
    int b, j;
    check({name, " idle"}, 38'h0);
    req_i = 1'b1;
    we_i = we;
    addr_i = addr;
    @(negedge clk_i);
    req_i = hold;
    we_i = 1'($urandom);
    addr_i = $urandom;
    for (int k = 1; k <= LAT + LW + 1; k++) begin
      j = k - LAT - 1;
      if (k <= LAT) check({name, " wait"}, {1'b1, 37'h0});
      else if (k <= LAT + LW) begin
        b = beat_of(we, addr, j);
        if (we) begin
          wdata_i = d[j];
          ref_mem[idx_of(addr, b)] = d[j];
          check({name, " wbeat"}, {4'b1010, 2'(b), 32'h0});
        end else check({name, " rbeat"}, {4'b1100, 2'(b), d[j]});
      end else check({name, " done"}, {4'b1001, 34'h0});
      @(negedge clk_i);
      wdata_i = $urandom;
    end
  endtask
  task automatic model_read(input string name, input logic [31:0] addr, input bit hold);
    line_t d;
    for (int j = 0; j < LW; j++) d[j] = ref_mem[idx_of(addr, beat_of(1'b0, addr, j))];
    burst(name, 1'b0, addr, d, hold);
  endtask
  initial begin
    la = mk(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    ld = mk(32'hD0, 32'hD1, 32'hD2, 32'hD3);
    lp = mk(32'hB0, 32'hB1, 32'hB2, 32'hB3);
    tbl[0] = '{1'b1, 32'h100, la};
    tbl[1] = '{1'b0, 32'h100, la};
    tbl[2] = '{1'b1, 32'h200, ld};
    tbl[3] = '{1'b0, 32'h200, ld};
`ifdef MEM_RESP_CWF_EN
    tbl[4] = '{1'b0, 32'h108, mk(32'hA2, 32'hA3, 32'hA0, 32'hA1)};
`else
    tbl[4] = '{1'b0, 32'h108, la};
`endif
    tbl[5] = '{1'b0, 32'h1103, la};
    tbl[6] = '{1'b1, 32'h300, lp};
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check("reset_idle", 38'h0);
    end
    @(negedge clk_i);
    for (int i = 0; i < 7; i++) burst($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].d, 1'b0);
    check("rst_pre", 38'h0);
    req_i = 1'b1;
    we_i = 1'b1;
    addr_i = 32'h300;
    @(negedge clk_i);
    req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    wdata_i = 32'hD0;
    check("rst_beat0", {4'b1010, 2'd0, 32'h0});
    @(negedge clk_i);
    wdata_i = 32'hD1;
    check("rst_beat1", {4'b1010, 2'd1, 32'h0});
    #1 rst_ni = 1'b0;
    #1 check("rst_mid", 38'h0);
    @(negedge clk_i);
    check("rst_held", 38'h0);
    rst_ni = 1'b1;
    ref_mem[idx_of(32'h300, 0)] = 32'hD0;
    @(negedge clk_i);
    burst("rst_after", 1'b0, 32'h300, mk(32'hD0, 32'hB1, 32'hB2, 32'hB3), 1'b0);
    model_read("b2b0", 32'h100, 1'b1);
    model_read("b2b1", 32'h208, 1'b1);
    burst("b2b2", 1'b1, 32'h3F0, mk($urandom, $urandom, $urandom, $urandom), 1'b1);
    model_read("b2b3", 32'h3F4, 1'b0);
    for (int l = 0; l < 8; l++)
      burst("rnd_init", 1'b1, 32'h800 | 32'(l << 4), mk($urandom, $urandom, $urandom, $urandom), 1'b0);
    for (int i = 0; i < 30; i++) begin
      logic [31:0] a;
      a = ($urandom << 12) | 32'h800 | 32'($urandom_range(0, 7) << 4) | 32'($urandom_range(0, 3) << 2) | ($urandom & 32'h3);
      if ($urandom_range(0, 2) == 0) burst("rnd_wr", 1'b1, a, mk($urandom, $urandom, $urandom, $urandom), 1'b0);
      else model_read("rnd_rd", a, 1'b0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_burst_responder.md
MEM_BURST_RESPONDER -- requirements
Module: mem_burst_responder

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 2**(CACHE_B-2): words per cache-line burst, power of two.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024: backing-store size in 32-bit words, power of two.
REQ-003 SHALL have parameter LATENCY, default 2: idle cycles between request acceptance and first beat, at least 1.
REQ-004 SHALL have ports, with clk_i the sole clock and rst_ni an asynchronous, active-low reset:
  - clk_i  input  1  sole clock, rising edge
  - rst_ni  input  1  asynchronous active-low reset
  - req_i  input  1  burst request from the cache controller
  - we_i  input  1  1 = write-back burst, 0 = line-fill burst
  - addr_i  input  32  byte address; bits [1:0] ignored
  - wdata_i  input  32  write-back data, sampled on write beats
  - busy_o  output  1  burst in progress; no new request accepted
  - rvalid_o  output  1  rdata_o valid this cycle
  - rdata_o  output  32  read beat data
  - wready_o  output  1  wdata_i sampled at this rising edge
  - beat_o  output  log2(LINE_WORDS)  word offset of the current beat
  - done_o  output  1  one-cycle pulse at burst completion

Function
REQ-005 SHALL implement FSM IDLE -> WAIT -> BURST -> DONE -> IDLE.
REQ-006 In IDLE with req_i=1, SHALL latch we_i, addr_i line base and addr_i word offset, then enter WAIT next cycle.
REQ-007 SHALL stay in WAIT exactly LATENCY cycles, then enter BURST.
REQ-008 SHALL stay in BURST exactly LINE_WORDS cycles, one beat per cycle, with no stall.
REQ-009 Read beat: SHALL assert rvalid_o with rdata_o = mem[line_base + beat_o] combinationally from the array.
REQ-010 Write beat: SHALL assert wready_o and write wdata_i to mem[line_base + beat_o] at the clock edge.
REQ-011 Without MEM_RESP_CWF_EN, beat_o SHALL run 0..LINE_WORDS-1.
REQ-012 SHALL hold DONE one cycle with done_o=1, then return to IDLE; first request after that SHALL be accepted in IDLE.
REQ-013 busy_o SHALL be 1 in WAIT, BURST and DONE, and 0 in IDLE.
REQ-014 SHALL ignore req_i, we_i and addr_i outside IDLE; deasserting req_i mid-burst SHALL NOT abort the burst.
REQ-015 Word index SHALL be taken modulo DEPTH_WORDS; out-of-range addresses SHALL alias and SHALL NOT error.
REQ-016 Read data: rvalid_o, rdata_o and beat_o SHALL be 0 whenever no beat is active.
REQ-017 Handshake: the requester samples rdata_o on rvalid_o, drives wdata_i for beat_o while wready_o is high, and expects the request-to-first-beat gap to be LATENCY+1 cycles.

Reset
REQ-018 rst_ni low SHALL force IDLE immediately and clear busy_o, rvalid_o, rdata_o, wready_o, beat_o, done_o and the beat/latency counters, including mid-burst; a partial write-back stays partial.
REQ-019 Memory array contents SHALL NOT be reset.

Configuration
REQ-020 With MEM_RESP_CWF_EN defined: read bursts SHALL start at the latched word offset and wrap modulo LINE_WORDS (critical word first); write bursts SHALL still run from 0.
REQ-021 Without MEM_RESP_CWF_EN: all bursts SHALL start at offset 0 and the latched offset SHALL be unused.

Structure
REQ-022 Package mem_resp_pkg SHALL hold the state enum (IDLE, WAIT, BURST, DONE) and the default LINE_WORDS and DEPTH_WORDS constants.
REQ-023 SHALL instantiate one sub-module, mem_resp_counter: a loadable, wrapping down/up counter shared by the WAIT and BURST phases.

Verification (LINE_WORDS=4, LATENCY=2, DEPTH_WORDS=1024)
REQ-024 Reset release, no request -> all outputs 0 and busy_o=0 for 10 cycles.
REQ-025 Preload mem[0x40..0x43]=A0..A3; read req with addr_i=0x100 at cycle 0 -> rvalid_o at cycles 3..6 with A0..A3 and beat_o 0..3, done_o at cycle 7, busy_o low at cycle 8.
REQ-026 Write req addr_i=0x200, wdata_i=D0..D3 on wready_o -> then a read of 0x200 returns D0..D3.
REQ-027 MEM_RESP_CWF_EN, read addr_i=0x108 -> beat_o sequence 2,3,0,1 with data A2,A3,A0,A1.
REQ-028 rst_ni pulsed low during beat 1 of a write to 0x300 -> outputs 0 immediately; mem[0xC0]=D0 written, mem[0xC2] unchanged; next request served normally.
REQ-029 req_i held high continuously, and addr_i changed mid-burst -> back-to-back bursts with exactly one IDLE cycle between them, each using the address latched at acceptance.
